// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg
//   EX->MEM pipeline register with valid/ready handshaking, synchronous
//   flush and bubble insertion. It also exports a forwarding tap for the
//   hazard unit and a saturating back-pressure counter.
//
//   Build option: define EX_MEM_SKID_EN to add a one-entry skid buffer.
//   With the skid buffer, in_ready is a register output, so there is no
//   combinational path from out_ready to in_ready. Without it, in_ready is
//   ~out_valid | out_ready.
//
// Ports
//   Clk, Rst_n        clock (posedge) and asynchronous active-low reset
//   flush             kill every held entry at the next edge
//   in_valid/in_ready handshake from the EX stage
//   ctrl_in, pc_in, alu_result_in, rs2_data_in, rd_in
//                     incoming payload
//   out_valid/out_ready
//                     handshake to the MEM stage
//   ctrl_out          control to MEM, forced to 0 while out_valid=0
//   pc_out, alu_result_out, rs2_data_out, rd_out
//                     held payload
//   fwd_en, fwd_rd    forwarding tap (RegWrite, valid entry, rd != 0)
//   stall_cnt         saturating count of cycles with out_valid & ~out_ready
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8,
  parameter int RW_BIT = 0,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] rs2_data_in,
  input  logic [REG_AW-1:0] rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] rs2_data_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              fwd_en,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              vld_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [DATA_W-1:0] alu_p1;
  logic [DATA_W-1:0] rs2_p1;
  logic [REG_AW-1:0] rd_p1;
  logic              xfer_in;

  assign xfer_in = in_valid & in_ready;

`ifdef EX_MEM_SKID_EN
  logic              skid_vld_p0;
  logic [CTRL_W-1:0] skid_ctrl_p0;
  logic [ADDR_W-1:0] skid_pc_p0;
  logic [DATA_W-1:0] skid_alu_p0;
  logic [DATA_W-1:0] skid_rs2_p0;
  logic [REG_AW-1:0] skid_rd_p0;
  logic              load_main;

  // The main register is free when empty or draining this cycle.
  // Accepting input only while the skid is empty keeps in_ready registered.
  assign in_ready  = ~skid_vld_p0;
  assign load_main = ~vld_p1 | out_ready;

  // Stage boundary: EX / skid -> MEM register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_p1       <= 1'b0;
      ctrl_p1      <= '0;
      pc_p1        <= '0;
      alu_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      skid_vld_p0  <= 1'b0;
      skid_ctrl_p0 <= '0;
      skid_pc_p0   <= '0;
      skid_alu_p0  <= '0;
      skid_rs2_p0  <= '0;
      skid_rd_p0   <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else if (load_main) begin
      // The skid entry is older than anything on the input, so it goes first.
      if (skid_vld_p0) begin
        vld_p1      <= 1'b1;
        ctrl_p1     <= skid_ctrl_p0;
        pc_p1       <= skid_pc_p0;
        alu_p1      <= skid_alu_p0;
        rs2_p1      <= skid_rs2_p0;
        rd_p1       <= skid_rd_p0;
        skid_vld_p0 <= 1'b0;
      end else if (xfer_in) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= ctrl_in;
        pc_p1   <= pc_in;
        alu_p1  <= alu_result_in;
        rs2_p1  <= rs2_data_in;
        rd_p1   <= rd_in;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (xfer_in) begin
      skid_vld_p0  <= 1'b1;
      skid_ctrl_p0 <= ctrl_in;
      skid_pc_p0   <= pc_in;
      skid_alu_p0  <= alu_result_in;
      skid_rs2_p0  <= rs2_data_in;
      skid_rd_p0   <= rd_in;
    end
  end
`else
  logic xfer_out;

  assign in_ready = ~vld_p1 | out_ready;
  assign xfer_out = vld_p1 & out_ready;

  // Stage boundary: EX -> MEM register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      pc_p1   <= '0;
      alu_p1  <= '0;
      rs2_p1  <= '0;
      rd_p1   <= '0;
    end else if (flush) begin
      // Flush wins over a same-cycle capture; the payload may stay stale.
      vld_p1 <= 1'b0;
    end else if (xfer_in) begin
      vld_p1  <= 1'b1;
      ctrl_p1 <= ctrl_in;
      pc_p1   <= pc_in;
      alu_p1  <= alu_result_in;
      rs2_p1  <= rs2_data_in;
      rd_p1   <= rd_in;
    end else if (xfer_out) begin
      vld_p1 <= 1'b0;
    end
  end
`endif

  // Stage boundary: MEM-side back-pressure counter (flush does not clear it)
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
    end else if (vld_p1 & ~out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign out_valid      = vld_p1;
  assign ctrl_out       = vld_p1 ? ctrl_p1 : '0;
  assign pc_out         = pc_p1;
  assign alu_result_out = alu_p1;
  assign rs2_data_out   = rs2_p1;
  assign rd_out         = rd_p1;
  assign fwd_en         = vld_p1 & ctrl_p1[RW_BIT] & (rd_p1 != '0);
  assign fwd_rd         = rd_p1;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Testbench for ex_mem_pipe_reg. Combines a table of per-cycle vectors
// with a FIFO scoreboard of accepted entries. The counter is narrowed to
// 4 bits so that saturation can be reached quickly.
module tb_ex_mem_pipe_reg;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready, fwd_en;
  logic [7:0]  ctrl_in, ctrl_out;
  logic [31:0] pc_in, pc_out, alu_result_in, alu_result_out, rs2_data_in, rs2_data_out;
  logic [4:0]  rd_in, rd_out, fwd_rd;
  logic [CNT_W-1:0] stall_cnt;

  ex_mem_pipe_reg #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .pc_in(pc_in), .alu_result_in(alu_result_in),
    .rs2_data_in(rs2_data_in), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .pc_out(pc_out), .alu_result_out(alu_result_out),
    .rs2_data_out(rs2_data_out), .rd_out(rd_out),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } ent_t;

  typedef struct {
    logic        v, r, f;
    logic [7:0]  ctrl;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        e_ov;
    logic [31:0] e_alu;
    logic        e_ir, e_fwd;
    logic [CNT_W-1:0] e_st;
  } vec_t;

  ent_t q[$];
  vec_t tbl[17];
  int   errors = 0;
  int   checks = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic xin, xout, st, cur_flush;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (at a negedge), then check against the scoreboard.
  task automatic drive(input logic v, r, f, input logic [7:0] c,
                       input logic [31:0] a, input logic [4:0] d);
    logic exp_ir;
    in_valid = v; out_ready = r; flush = f; ctrl_in = c;
    alu_result_in = a; rs2_data_in = ~a; pc_in = a + 32'h1000; rd_in = d;
    #1;
`ifdef EX_MEM_SKID_EN
    exp_ir = (q.size() < 2);
`else
    exp_ir = (q.size() == 0) || r;
`endif
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("ctrl_out", ctrl_out, q[0].ctrl);
      chk("pc_out", pc_out, q[0].pc);
      chk("alu_out", alu_result_out, q[0].alu);
      chk("rs2_out", rs2_data_out, q[0].rs2);
      chk("rd_out", rd_out, q[0].rd);
      chk("fwd_en", fwd_en, q[0].ctrl[0] && (q[0].rd != 0));
      chk("fwd_rd", fwd_rd, q[0].rd);
    end else begin
      chk("ctrl_out_idle", ctrl_out, 0);
      chk("fwd_en_idle", fwd_en, 0);
    end
    chk("stall_cnt", stall_cnt, exp_stall);
    xin  = v & exp_ir;
    xout = (q.size() != 0) & r;
    st   = (q.size() != 0) & ~r;
    cur_flush = f;
  endtask

  task automatic advance();
    @(posedge Clk);
    if (st && exp_stall != CMAX) exp_stall = exp_stall + 1'b1;
    if (cur_flush) q.delete();
    else begin
      if (xout) void'(q.pop_front());
      if (xin) q.push_back('{ctrl: ctrl_in, pc: pc_in, alu: alu_result_in,
                              rs2: rs2_data_in, rd: rd_in});
    end
    @(negedge Clk);
  endtask

  task automatic step(input logic v, r, f, input logic [7:0] c,
                      input logic [31:0] a, input logic [4:0] d);
    drive(v, r, f, c, a, d);
    advance();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //            v  r  f  ctrl   alu        rd   e_ov e_alu      ir fwd st
    tbl[0]  = '{1, 1, 0, 8'h01, 32'h10,   1,   0, 32'h0,    1, 0, 0};
    tbl[1]  = '{1, 1, 0, 8'h01, 32'h20,   2,   1, 32'h10,   1, 1, 0};
    tbl[2]  = '{1, 1, 0, 8'h01, 32'h30,   3,   1, 32'h20,   1, 1, 0};
    tbl[3]  = '{0, 1, 0, 8'h00, 32'h0,    0,   1, 32'h30,   1, 1, 0};
    tbl[4]  = '{1, 0, 0, 8'h04, 32'hABCD, 4,   0, 32'h0,    1, 0, 0};
    tbl[5]  = '{1, 0, 0, 8'h01, 32'h55,   6,   1, 32'hABCD, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 8'h01, 32'h55,   6,   1, 32'hABCD, 0, 0, 1};
    tbl[7]  = '{1, 0, 0, 8'h01, 32'h55,   6,   1, 32'hABCD, 0, 0, 2};
    tbl[8]  = '{0, 1, 0, 8'h00, 32'h0,    0,   1, 32'hABCD, 1, 0, 3};
    tbl[9]  = '{1, 1, 0, 8'h01, 32'h77,   5,   0, 32'h0,    1, 0, 3};
    tbl[10] = '{1, 1, 1, 8'h01, 32'h88,   9,   1, 32'h77,   1, 1, 3};
    tbl[11] = '{0, 1, 0, 8'h00, 32'h0,    0,   0, 32'h0,    1, 0, 3};
    tbl[12] = '{1, 1, 0, 8'h01, 32'h99,   0,   0, 32'h0,    1, 0, 3};
    tbl[13] = '{1, 1, 0, 8'h01, 32'hAA,   7,   1, 32'h99,   1, 0, 3};
    tbl[14] = '{0, 1, 0, 8'h00, 32'h0,    0,   1, 32'hAA,   1, 1, 3};
    tbl[15] = '{1, 1, 0, 8'h00, 32'hBB,   7,   0, 32'h0,    1, 0, 3};
    tbl[16] = '{0, 1, 0, 8'h00, 32'h0,    0,   1, 32'hBB,   1, 0, 3};

    Rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
    ctrl_in = 0; pc_in = 0; alu_result_in = 0; rs2_data_in = 0; rd_in = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctrl_out", ctrl_out, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_fwd_en", fwd_en, 0);
    chk("rst_alu_out", alu_result_out, 0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Streaming, stall, flush and forwarding vectors
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].ctrl, tbl[i].alu, tbl[i].rd);
`ifndef EX_MEM_SKID_EN
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_ir", i), in_ready, tbl[i].e_ir);
      chk($sformatf("tbl%0d_fwd", i), fwd_en, tbl[i].e_fwd);
      chk($sformatf("tbl%0d_st", i), stall_cnt, tbl[i].e_st);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_alu", i), alu_result_out, tbl[i].e_alu);
      if (i == 14) chk("tbl14_fwd_rd", fwd_rd, 7);
`endif
      advance();
    end

    // Counter saturation under a long stall
    step(1, 0, 0, 8'h01, 32'hC0DE, 2);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 8'h00, 32'h0, 0);
    drive(0, 1, 0, 8'h00, 32'h0, 0);
    chk("stall_saturated", stall_cnt, 32'(CMAX));
    advance();

`ifdef EX_MEM_SKID_EN
    // Two entries under back-pressure, then released in order
    step(1, 0, 0, 8'h01, 32'hA, 10);
    step(1, 0, 0, 8'h01, 32'hB, 11);
    drive(0, 0, 0, 8'h00, 32'h0, 0);
    chk("skid_full_ir", in_ready, 0);
    advance();
    drive(0, 1, 0, 8'h00, 32'h0, 0);
    chk("skid_first_A", alu_result_out, 32'hA);
    advance();
    drive(0, 1, 0, 8'h00, 32'h0, 0);
    chk("skid_second_B", alu_result_out, 32'hB);
    advance();
    drive(0, 1, 0, 8'h00, 32'h0, 0);
    chk("skid_drained_ir", in_ready, 1);
    advance();
    // Flush with both entries held
    step(1, 0, 0, 8'h01, 32'hC, 12);
    step(1, 0, 0, 8'h01, 32'hD, 13);
    step(0, 0, 1, 8'h00, 32'h0, 0);
    step(0, 1, 0, 8'h00, 32'h0, 0);
`endif

    // Asynchronous reset in the middle of a stall
    step(1, 0, 0, 8'h01, 32'h5A5A, 3);
    step(0, 0, 0, 8'h00, 32'h0, 0);
    #2 Rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_ctrl_out", ctrl_out, 0);
    chk("midrst_stall_cnt", stall_cnt, 0);
    chk("midrst_fwd_en", fwd_en, 0);
    q.delete();
    exp_stall = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    step(1, 1, 0, 8'h01, 32'h1234, 8);
    step(0, 1, 0, 8'h00, 32'h0, 0);
    step(0, 1, 0, 8'h00, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
